// File: rtl/issue_queue.sv
// Collapsing, age-ordered issue queue feeding PhysRegFile. Entry 0 is always the oldest;
// the oldest entry with both sources ready is issued into registered outputs.
module issue_queue #(
  parameter int unsigned NUM_ENTRIES   = 8,
  parameter int unsigned NUM_PHYS_REGS = 64,
  localparam int unsigned LOG_PHYS     = $clog2(NUM_PHYS_REGS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                STALL,
  input  logic                FLUSH,
  input  logic                Dispatch_Valid,
  output logic                Dispatch_Ready,
  input  logic [LOG_PHYS-1:0] srcA_IN,
  input  logic [LOG_PHYS-1:0] srcB_IN,
  input  logic [LOG_PHYS-1:0] dest_IN,
  input  logic                srcA_Rdy_IN,
  input  logic                srcB_Rdy_IN,
  input  logic [31:0]         Instr1_IN,
  input  logic [31:0]         Instr1_PC_IN,
  input  logic [5:0]          ALU_Control1_IN,
  input  logic                MemRead1_IN,
  input  logic                MemWrite1_IN,
  input  logic [4:0]          ShiftAmount1_IN,
  input  logic [LOG_PHYS-1:0] DCacheReg_IN,
  input  logic                DCache_Valid,
  input  logic [LOG_PHYS-1:0] EXEReg_IN,
  input  logic                EXE_Valid,
  output logic                Issue_Valid,
  output logic [LOG_PHYS-1:0] srcA_OUT,
  output logic [LOG_PHYS-1:0] srcB_OUT,
  output logic [LOG_PHYS-1:0] dest_OUT,
  output logic [31:0]         Instr1_OUT,
  output logic [31:0]         Instr1_PC_OUT,
  output logic [5:0]          ALU_Control1_OUT,
  output logic                MemRead1_OUT,
  output logic                MemWrite1_OUT,
  output logic [4:0]          ShiftAmount1_OUT
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
  localparam int unsigned CntW = $clog2(NUM_ENTRIES + 1);

  typedef struct packed {
    logic                valid;
    logic                rdya;
    logic                rdyb;
    logic [LOG_PHYS-1:0] srca;
    logic [LOG_PHYS-1:0] srcb;
    logic [LOG_PHYS-1:0] dest;
    logic [31:0]         instr;
    logic [31:0]         pc;
    logic [5:0]          alu;
    logic                mem_read;
    logic                mem_write;
    logic [4:0]          shamt;
  } entry_t;

  entry_t            ent_q [NUM_ENTRIES];
  entry_t            ent_d [NUM_ENTRIES];
  entry_t            woke  [NUM_ENTRIES];
  entry_t            new_ent;
  entry_t            sel_ent;
  logic [CntW-1:0]   count_q, count_d;
  logic              found;
  logic [IdxW-1:0]   sel_idx;
  logic [IdxW-1:0]   ins_idx;
  logic              do_issue;
  logic              accept;

  function automatic logic tag_hit(input logic [LOG_PHYS-1:0] tag,
                                   input logic dv, input logic [LOG_PHYS-1:0] dt,
                                   input logic ev, input logic [LOG_PHYS-1:0] et);
    return (dv && (tag == dt)) || (ev && (tag == et));
  endfunction

  assign Dispatch_Ready = (count_q < CntW'(NUM_ENTRIES));

  // Oldest-first select on registered ready bits only.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].rdya && ent_q[i].rdyb) begin
        found   = 1'b1;
        sel_idx = IdxW'(i);
      end
    end
  end

  assign sel_ent  = ent_q[sel_idx];
  assign do_issue = found && !STALL && !FLUSH;
  assign accept   = Dispatch_Valid && Dispatch_Ready && !FLUSH;
  assign ins_idx  = IdxW'(count_q - CntW'(do_issue));

  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.srca      = srcA_IN;
    new_ent.srcb      = srcB_IN;
    new_ent.rdya      = srcA_Rdy_IN ||
                        tag_hit(srcA_IN, DCache_Valid, DCacheReg_IN, EXE_Valid, EXEReg_IN);
    new_ent.rdyb      = srcB_Rdy_IN ||
                        tag_hit(srcB_IN, DCache_Valid, DCacheReg_IN, EXE_Valid, EXEReg_IN);
    new_ent.dest      = dest_IN;
    new_ent.instr     = Instr1_IN;
    new_ent.pc        = Instr1_PC_IN;
    new_ent.alu       = ALU_Control1_IN;
    new_ent.mem_read  = MemRead1_IN;
    new_ent.mem_write = MemWrite1_IN;
    new_ent.shamt     = ShiftAmount1_IN;
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      woke[i] = ent_q[i];
      if (ent_q[i].valid) begin
        woke[i].rdya = ent_q[i].rdya ||
                       tag_hit(ent_q[i].srca, DCache_Valid, DCacheReg_IN, EXE_Valid, EXEReg_IN);
        woke[i].rdyb = ent_q[i].rdyb ||
                       tag_hit(ent_q[i].srcb, DCache_Valid, DCacheReg_IN, EXE_Valid, EXEReg_IN);
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_d[i] = woke[i];
    end
    // Collapse: everything younger than the issued entry moves down one slot.
    if (do_issue) begin
      for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
        if (IdxW'(i) >= sel_idx) begin
          ent_d[i] = woke[i+1];
        end
      end
      ent_d[NUM_ENTRIES-1] = '0;
    end
    if (accept) begin
      ent_d[ins_idx] = new_ent;
    end
    if (FLUSH) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_d[i] = '0;
      end
    end
    count_d = FLUSH ? '0 : count_q + CntW'(accept) - CntW'(do_issue);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Issue_Valid      <= 1'b0;
      srcA_OUT         <= '0;
      srcB_OUT         <= '0;
      dest_OUT         <= '0;
      Instr1_OUT       <= '0;
      Instr1_PC_OUT    <= '0;
      ALU_Control1_OUT <= '0;
      MemRead1_OUT     <= 1'b0;
      MemWrite1_OUT    <= 1'b0;
      ShiftAmount1_OUT <= '0;
    end else if (FLUSH) begin
      Issue_Valid <= 1'b0;
    end else if (!STALL) begin
      Issue_Valid <= found;
      if (found) begin
        srcA_OUT         <= sel_ent.srca;
        srcB_OUT         <= sel_ent.srcb;
        dest_OUT         <= sel_ent.dest;
        Instr1_OUT       <= sel_ent.instr;
        Instr1_PC_OUT    <= sel_ent.pc;
        ALU_Control1_OUT <= sel_ent.alu;
        MemRead1_OUT     <= sel_ent.mem_read;
        MemWrite1_OUT    <= sel_ent.mem_write;
        ShiftAmount1_OUT <= sel_ent.shamt;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: hand-computed vector table, directed corner sequences, and a
// random run against a queue-based reference model.
module tb_issue_queue;

  localparam int N = 8;

  logic        CLK = 1'b0;
  logic        RESET, STALL, FLUSH, Dispatch_Valid, Dispatch_Ready;
  logic [5:0]  srcA_IN, srcB_IN, dest_IN, DCacheReg_IN, EXEReg_IN;
  logic        srcA_Rdy_IN, srcB_Rdy_IN, DCache_Valid, EXE_Valid;
  logic [31:0] Instr1_IN, Instr1_PC_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        MemRead1_IN, MemWrite1_IN;
  logic [4:0]  ShiftAmount1_IN;
  logic        Issue_Valid;
  logic [5:0]  srcA_OUT, srcB_OUT, dest_OUT;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT;
  logic [5:0]  ALU_Control1_OUT;
  logic        MemRead1_OUT, MemWrite1_OUT;
  logic [4:0]  ShiftAmount1_OUT;

  int tests = 0;
  int fails = 0;

  issue_queue #(.NUM_ENTRIES(N), .NUM_PHYS_REGS(64)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .Dispatch_Valid(Dispatch_Valid), .Dispatch_Ready(Dispatch_Ready),
    .srcA_IN(srcA_IN), .srcB_IN(srcB_IN), .dest_IN(dest_IN),
    .srcA_Rdy_IN(srcA_Rdy_IN), .srcB_Rdy_IN(srcB_Rdy_IN),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN), .ALU_Control1_IN(ALU_Control1_IN),
    .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN), .ShiftAmount1_IN(ShiftAmount1_IN),
    .DCacheReg_IN(DCacheReg_IN), .DCache_Valid(DCache_Valid),
    .EXEReg_IN(EXEReg_IN), .EXE_Valid(EXE_Valid),
    .Issue_Valid(Issue_Valid), .srcA_OUT(srcA_OUT), .srcB_OUT(srcB_OUT), .dest_OUT(dest_OUT),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT), .ALU_Control1_OUT(ALU_Control1_OUT),
    .MemRead1_OUT(MemRead1_OUT), .MemWrite1_OUT(MemWrite1_OUT),
    .ShiftAmount1_OUT(ShiftAmount1_OUT)
  );

  always #5 CLK = ~CLK;

  // Reference model: an age-ordered list of waiting instructions.
  typedef struct {
    logic [5:0]  sa, sb, dest;
    bit          ra, rb;
    logic [31:0] instr, pc;
    logic [5:0]  alu;
    logic        mr, mw;
    logic [4:0]  sh;
  } ment_t;

  ment_t mq[$];
  ment_t m_out;
  bit    m_iv;

  function automatic bit mhit(logic [5:0] t);
    return (DCache_Valid && t == DCacheReg_IN) || (EXE_Valid && t == EXEReg_IN);
  endfunction

  task automatic model_clock();
    int    sel;
    bit    room;
    ment_t e;
    sel  = -1;
    room = mq.size() < N;
    if (FLUSH) begin
      mq.delete();
      m_iv = 0;
      return;
    end
    if (!STALL) begin
      foreach (mq[i]) if (sel < 0 && mq[i].ra && mq[i].rb) sel = i;
      m_iv = (sel >= 0);
      if (sel >= 0) m_out = mq[sel];
    end
    foreach (mq[i]) begin
      if (mhit(mq[i].sa)) mq[i].ra = 1;
      if (mhit(mq[i].sb)) mq[i].rb = 1;
    end
    if (sel >= 0) mq.delete(sel);
    if (Dispatch_Valid && room) begin
      e.sa = srcA_IN; e.sb = srcB_IN; e.dest = dest_IN;
      e.ra = srcA_Rdy_IN || mhit(srcA_IN);
      e.rb = srcB_Rdy_IN || mhit(srcB_IN);
      e.instr = Instr1_IN; e.pc = Instr1_PC_IN; e.alu = ALU_Control1_IN;
      e.mr = MemRead1_IN; e.mw = MemWrite1_IN; e.sh = ShiftAmount1_IN;
      mq.push_back(e);
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    STALL = 0; FLUSH = 0; Dispatch_Valid = 0;
    srcA_IN = 0; srcB_IN = 0; dest_IN = 0; srcA_Rdy_IN = 0; srcB_Rdy_IN = 0;
    DCache_Valid = 0; DCacheReg_IN = 0; EXE_Valid = 0; EXEReg_IN = 0;
  endtask

  task automatic rand_payload();
    Instr1_IN = $urandom; Instr1_PC_IN = $urandom; ALU_Control1_IN = 6'($urandom);
    MemRead1_IN = 1'($urandom); MemWrite1_IN = 1'($urandom);
    ShiftAmount1_IN = 5'($urandom);
  endtask

  task automatic disp(int sa, int sb, bit ra, bit rb, int dst);
    Dispatch_Valid = 1; srcA_IN = 6'(sa); srcB_IN = 6'(sb);
    srcA_Rdy_IN = ra; srcB_Rdy_IN = rb; dest_IN = 6'(dst);
    rand_payload();
  endtask

  task automatic chk_zero_outputs(string nm);
    chk({nm, "_iv"}, 64'(Issue_Valid), 0);
    chk({nm, "_outs"}, {srcA_OUT, srcB_OUT, dest_OUT, ALU_Control1_OUT, MemRead1_OUT,
                        MemWrite1_OUT, ShiftAmount1_OUT}, 0);
    chk({nm, "_instr_pc"}, {Instr1_OUT, Instr1_PC_OUT}, 0);
    chk({nm, "_dready"}, 64'(Dispatch_Ready), 1);
  endtask

  task automatic chk_issue(string nm, bit iv, int sa, int sb);
    chk({nm, "_iv"}, 64'(Issue_Valid), 64'(iv));
    if (iv) chk({nm, "_srcs"}, {srcA_OUT, srcB_OUT}, {6'(sa), 6'(sb)});
  endtask

  typedef struct {
    bit dv; int sa, sb; bit ra, rb; int dest;
    bit dcv; int dct; bit exv; int ext;
    bit iv; int esa, esb, edest;
  } vec_t;

  vec_t vt[19];

  initial begin
    // dv sa sb ra rb dest | dcv dct exv ext | iv esa esb edest (outputs after the edge)
    vt[0]  = '{1, 3, 4, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 3, 4, 10};
    vt[2]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{1, 5, 6, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{1, 1, 2, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[5]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 5, 1, 1, 2, 12};
    vt[6]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 5, 6, 11};
    vt[7]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    vt[8]  = '{1, 7, 8, 0, 1, 13, 1, 7, 0, 0, 0, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 7, 8, 13};
    vt[10] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    vt[11] = '{1, 0, 0, 0, 0, 14, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[12] = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0};
    vt[13] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 14};
    vt[14] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    vt[15] = '{1, 9, 10, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[16] = '{0, 0, 0, 0, 0, 0,  1, 9, 1, 10, 0, 0, 0, 0};
    vt[17] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 9, 10, 15};
    vt[18] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};

    idle_inputs();
    rand_payload();
    RESET = 1;
    m_iv = 0;
    m_out = '{default: '0};
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk_zero_outputs("reset");
    @(negedge CLK);
    RESET = 0;

    foreach (vt[k]) begin
      idle_inputs();
      if (vt[k].dv) disp(vt[k].sa, vt[k].sb, vt[k].ra, vt[k].rb, vt[k].dest);
      DCache_Valid = vt[k].dcv; DCacheReg_IN = 6'(vt[k].dct);
      EXE_Valid = vt[k].exv; EXEReg_IN = 6'(vt[k].ext);
      step();
      chk($sformatf("vec%0d_iv", k), 64'(Issue_Valid), 64'(vt[k].iv));
      if (vt[k].iv)
        chk($sformatf("vec%0d_regs", k), {srcA_OUT, srcB_OUT, dest_OUT},
            {6'(vt[k].esa), 6'(vt[k].esb), 6'(vt[k].edest)});
    end

    // Stall: issue regs freeze while dispatch continues; oldest goes first on release.
    idle_inputs(); disp(50, 60, 1, 1, 1); step(); chk_issue("stall_c0", 0, 0, 0);
    idle_inputs(); disp(51, 61, 1, 1, 2); step(); chk_issue("stall_c1", 1, 50, 60);
    idle_inputs(); disp(52, 62, 1, 1, 3); step(); chk_issue("stall_c2", 1, 51, 61);
    idle_inputs(); disp(53, 63, 1, 1, 4); STALL = 1; step(); chk_issue("stall_c3", 1, 51, 61);
    idle_inputs(); STALL = 1; step(); chk_issue("stall_c4", 1, 51, 61);
    idle_inputs(); STALL = 1; step(); chk_issue("stall_c5", 1, 51, 61);
    idle_inputs(); step(); chk_issue("stall_rel0", 1, 52, 62);
    idle_inputs(); step(); chk_issue("stall_rel1", 1, 53, 63);
    idle_inputs(); step(); chk_issue("stall_rel2", 0, 0, 0);

    // Fill to capacity with waiting entries; a ninth dispatch must be dropped.
    for (int i = 0; i < N; i++) begin
      idle_inputs(); disp(20 + i, 40, 0, 1, i); step();
    end
    chk("full_dready", 64'(Dispatch_Ready), 0);
    idle_inputs(); disp(30, 31, 1, 1, 33); step();
    chk_issue("full_drop", 0, 0, 0);
    chk("full_dready2", 64'(Dispatch_Ready), 0);
    idle_inputs(); DCache_Valid = 1; DCacheReg_IN = 20; step();
    chk_issue("full_wake", 0, 0, 0);
    idle_inputs(); step();
    chk_issue("full_issue", 1, 20, 40);
    chk("full_dready3", 64'(Dispatch_Ready), 1);

    // Flush with seven entries and a valid issue, under stall and a competing dispatch.
    idle_inputs(); FLUSH = 1; STALL = 1; disp(1, 2, 1, 1, 5); step();
    chk("flush_iv", 64'(Issue_Valid), 0);
    chk("flush_dready", 64'(Dispatch_Ready), 1);
    idle_inputs(); DCache_Valid = 1; DCacheReg_IN = 21; step();
    chk_issue("flush_after0", 0, 0, 0);
    idle_inputs(); step();
    chk_issue("flush_after1", 0, 0, 0);

    // Random traffic against the model, with an asynchronous reset mid-burst.
    for (int c = 0; c < 3000; c++) begin
      STALL          = ($urandom_range(0, 99) < 20);
      FLUSH          = ($urandom_range(0, 99) < 3);
      Dispatch_Valid = ($urandom_range(0, 99) < 60);
      srcA_IN = 6'($urandom_range(0, 15)); srcB_IN = 6'($urandom_range(0, 15));
      dest_IN = 6'($urandom);
      srcA_Rdy_IN = 1'($urandom); srcB_Rdy_IN = 1'($urandom);
      DCache_Valid = 1'($urandom); DCacheReg_IN = 6'($urandom_range(0, 15));
      EXE_Valid = 1'($urandom); EXEReg_IN = 6'($urandom_range(0, 15));
      rand_payload();
      step();
      chk("rnd_iv", 64'(Issue_Valid), 64'(m_iv));
      chk("rnd_dready", 64'(Dispatch_Ready), 64'(mq.size() < N));
      if (m_iv) begin
        chk("rnd_pregs", {srcA_OUT, srcB_OUT, dest_OUT}, {m_out.sa, m_out.sb, m_out.dest});
        chk("rnd_instr_pc", {Instr1_OUT, Instr1_PC_OUT}, {m_out.instr, m_out.pc});
        chk("rnd_side", {ALU_Control1_OUT, MemRead1_OUT, MemWrite1_OUT, ShiftAmount1_OUT},
            {m_out.alu, m_out.mr, m_out.mw, m_out.sh});
      end
      if (c == 1500) begin
        #1 RESET = 1;
        #1 chk_zero_outputs("async_reset");
        #1 RESET = 0;
        mq.delete();
        m_iv = 0;
        m_out = '{default: '0};
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
